// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Collapsing, age-ordered issue queue that sits directly after rename. It
// accepts renamed instructions in program order and holds each one until all
// of its valid sources are ready. Sources are woken up by the physical-register
// broadcast. The oldest ready entry is offered to execute through a
// valid/ready handshake.
//
// Slots [0 .. count-1] hold live entries, with slot 0 the oldest. Every slot
// at or above count holds all zeros. Removing an entry compacts every younger
// entry down by one slot, so age order is never disturbed.
//
// Optional feature (compile-time macro):
//   IQ_FLUSH_EN : a mispredicted branch (br_result_i valid, hit clear) clears
//                 the whole queue in that cycle. When the macro is undefined,
//                 br_result_i is ignored and no flush logic exists.
//
// Packed port layouts (MSB first):
//   rinstr_t    [24:0] : {valid, rd, rs1, rs2}
//                        each operand [7:0] is {valid, idx[5:0], ready}
//   p_reg_t     [6:0]  : {valid, idx[5:0]}
//   br_result_t [1:0]  : {valid, hit}
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   rinstr_i       renamed instruction from rename
//   p_wb_i         wakeup broadcast
//   br_result_i    branch outcome (used only with IQ_FLUSH_EN)
//   issue_ready_i  execute stage can accept an instruction this cycle
//   issue_o        oldest ready instruction; all zeros when nothing issuable
//   iq_full_o      queue cannot accept rinstr_i this cycle
//   iq_count_o     number of occupied slots
// -----------------------------------------------------------------------------
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [24:0]      rinstr_i,
    input  logic [6:0]       p_wb_i,
    input  logic [1:0]       br_result_i,
    input  logic             issue_ready_i,
    output logic [24:0]      issue_o,
    output logic             iq_full_o,
    output logic [CNT_W-1:0] iq_count_o
);

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } src_t;

    typedef struct packed {
        logic valid;
        src_t rd;
        src_t rs1;
        src_t rs2;
    } rinstr_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic src_t wake_src(src_t s, logic wb_valid, logic [5:0] wb_idx);
        src_t r;
        r = s;
        if (wb_valid && s.valid && (s.idx == wb_idx)) begin
            r.ready = 1'b1;
        end
        return r;
    endfunction

    // Destination fields are never touched by a wakeup.
    function automatic rinstr_t wake_entry(rinstr_t e, logic wb_valid, logic [5:0] wb_idx);
        rinstr_t r;
        r     = e;
        r.rs1 = wake_src(e.rs1, wb_valid, wb_idx);
        r.rs2 = wake_src(e.rs2, wb_valid, wb_idx);
        return r;
    endfunction

    function automatic logic entry_ready(rinstr_t e);
        return (!e.rs1.valid || e.rs1.ready) && (!e.rs2.valid || e.rs2.ready);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    rinstr_t          slots_q [DEPTH];
    rinstr_t          slots_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // -------------------------------------------------------------------------
    // Input decode
    // -------------------------------------------------------------------------
    rinstr_t    enq_entry;
    logic       wb_valid;
    logic [5:0] wb_idx;
    logic       flush;

    assign enq_entry = rinstr_i;
    assign wb_valid  = p_wb_i[6];
    assign wb_idx    = p_wb_i[5:0];

`ifdef IQ_FLUSH_EN
    assign flush = br_result_i[1] && !br_result_i[0];
`else
    logic unused_br_result;
    assign unused_br_result = ^br_result_i;
    assign flush            = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Select: lowest-index ready slot among the occupied ones
    // -------------------------------------------------------------------------
    logic             sel_found;
    logic [CNT_W-1:0] sel_idx;
    rinstr_t          sel_entry;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && (CNT_W'(i) < count_q) && entry_ready(slots_q[i])) begin
                sel_found = 1'b1;
                sel_idx   = CNT_W'(i);
                sel_entry = slots_q[i];
            end
        end
    end

    rinstr_t issue_entry;
    logic    do_issue;
    logic    do_enq;

    // A flush cycle suppresses the offer so no handshake can complete.
    assign issue_entry = (sel_found && !flush) ? sel_entry : '0;
    assign issue_o     = issue_entry;
    assign do_issue    = issue_entry.valid && issue_ready_i;

    // Full depends only on registered count; a same-cycle issue gives no credit.
    assign iq_full_o   = (count_q == CNT_W'(DEPTH));
    assign iq_count_o  = count_q;
    assign do_enq      = enq_entry.valid && !iq_full_o;

    // -------------------------------------------------------------------------
    // Next state: compact past the issued slot, wake up, then append
    // -------------------------------------------------------------------------
    // ext carries one extra all-zero slot so the top slot shifts in zeros
    // without an out-of-range read.
    rinstr_t          ext [DEPTH+1];
    logic [CNT_W-1:0] cnt_mid;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ext[i] = slots_q[i];
        end
        ext[DEPTH] = '0;

        cnt_mid = count_q - CNT_W'(do_issue);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_issue && (CNT_W'(i) >= sel_idx)) begin
                slots_d[i] = ext[i+1];
            end else begin
                slots_d[i] = ext[i];
            end
            slots_d[i] = wake_entry(slots_d[i], wb_valid, wb_idx);

            // The incoming entry lands just behind the surviving entries and
            // sees the same-cycle wakeup.
            if (do_enq && (CNT_W'(i) == cnt_mid)) begin
                slots_d[i] = wake_entry(enq_entry, wb_valid, wb_idx);
            end
        end

        count_d = cnt_mid + CNT_W'(do_enq);

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//
// Self-checking bench for issue_queue. A queue-based reference model holds the
// live entries in age order; each cycle the expected outputs come from that
// model, and after the clock edge the model removes the issued entry, applies
// the wakeup and appends the accepted instruction.
// Honours IQ_FLUSH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

`ifdef IQ_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } src_t;

    typedef struct packed {
        logic valid;
        src_t rd;
        src_t rs1;
        src_t rs2;
    } instr_t;

    logic             clk = 1'b0;
    logic             rst_n;
    instr_t           rin;
    logic [6:0]       wb;
    logic [1:0]       br;
    logic             rdy;
    instr_t           issue;
    logic             full;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rinstr_i      (rin),
        .p_wb_i        (wb),
        .br_result_i   (br),
        .issue_ready_i (rdy),
        .issue_o       (issue),
        .iq_full_o     (full),
        .iq_count_o    (count)
    );

    // ---------------- reference model ----------------
    instr_t           q[$];
    instr_t           exp_issue;
    logic             exp_full;
    logic [CNT_W-1:0] exp_count;
    int               exp_sel;
    int               checks   = 0;
    int               failures = 0;
    instr_t           nop;

    function automatic bit is_ready(instr_t e);
        return (!e.rs1.valid || e.rs1.ready) && (!e.rs2.valid || e.rs2.ready);
    endfunction

    function automatic instr_t woken(instr_t e, logic [6:0] w);
        instr_t r = e;
        if (w[6]) begin
            if (e.rs1.valid && e.rs1.idx == w[5:0]) r.rs1.ready = 1'b1;
            if (e.rs2.valid && e.rs2.idx == w[5:0]) r.rs2.ready = 1'b1;
        end
        return r;
    endfunction

    function automatic bit flush_of(logic [1:0] b);
        return FLUSH_EN && b[1] && !b[0];
    endfunction

    function automatic instr_t mk(int rd, bit s1v, int s1, bit s1r, bit s2v, int s2, bit s2r);
        instr_t e = '0;
        e.valid     = 1'b1;
        e.rd.valid  = 1'b1;
        e.rd.idx    = 6'(rd);
        e.rs1.valid = s1v;
        e.rs1.idx   = 6'(s1);
        e.rs1.ready = s1r;
        e.rs2.valid = s2v;
        e.rs2.idx   = 6'(s2);
        e.rs2.ready = s2r;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and form expectations.
    task automatic drive(input instr_t r, input logic [6:0] w, input logic [1:0] b, input logic rd_i);
        @(negedge clk);
        rin = r;
        wb  = w;
        br  = b;
        rdy = rd_i;
        #1;
        exp_sel = -1;
        foreach (q[k]) if (exp_sel < 0 && is_ready(q[k])) exp_sel = k;
        exp_issue = (flush_of(br) || exp_sel < 0) ? '0 : q[exp_sel];
        exp_full  = (q.size() == DEPTH);
        exp_count = CNT_W'(q.size());
    endtask

    // Advance the model across the coming rising edge.
    task automatic tick();
        if (flush_of(br)) begin
            q.delete();
        end else begin
            if (exp_issue.valid && rdy) q.delete(exp_sel);
            foreach (q[k]) q[k] = woken(q[k], wb);
            if (rin.valid && !exp_full) q.push_back(woken(rin, wb));
        end
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rin = '0; wb = '0; br = '0; rdy = 1'b0;
        #3;
        checks++;
        if ({issue, full, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: issue=%h full=%b count=%0d, expected all zero", issue, full, count);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_fill_issue();
        for (int i = 0; i < DEPTH; i++) begin
            drive(mk(32 + i, 0, 0, 0, 0, 0, 0), '0, '0, 1'b0);
            checks++;
            if ({issue, full, count} !== {exp_issue, exp_full, exp_count}) begin
                failures++;
                $display("FAIL fill_%0d: issue=%h full=%b count=%0d, expected %h %b %0d", i, issue, full, count, exp_issue, exp_full, exp_count);
            end
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(nop, '0, '0, 1'b1);
            checks++;
            if ({issue, full, count} !== {exp_issue, exp_full, exp_count}) begin
                failures++;
                $display("FAIL drain_%0d: issue=%h full=%b count=%0d, expected %h %b %0d", i, issue, full, count, exp_issue, exp_full, exp_count);
            end
            checks++;
            if (issue.rd.idx !== 6'(32 + i)) begin
                failures++;
                $display("FAIL drain_order_%0d: rd=%0d, expected %0d", i, issue.rd.idx, 32 + i);
            end
            if (i == 0) begin
                checks++;
                if (full !== 1'b1 || count !== 4'd8) begin
                    failures++;
                    $display("FAIL full_flag: full=%b count=%0d, expected 1 8", full, count);
                end
            end
            if (i == 1) begin
                checks++;
                if (full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_deassert: full=%b, expected 0", full);
                end
            end
            tick();
        end
    endtask

    task automatic test_out_of_order();
        drive(mk(50, 1, 40, 0, 0, 0, 0), '0, '0, 1'b0); tick();
        drive(mk(41, 1, 3, 1, 0, 0, 0), '0, '0, 1'b0);  tick();
        drive(nop, '0, '0, 1'b1);
        checks++;
        if (issue.valid !== 1'b1 || issue.rd.idx !== 6'd41 || issue !== exp_issue) begin
            failures++;
            $display("FAIL ooo_young_first: issue=%h, expected %h (rd 41)", issue, exp_issue);
        end
        tick();
        drive(nop, 7'h40 | 7'd40, '0, 1'b1);
        checks++;
        if (issue !== '0 || issue !== exp_issue) begin
            failures++;
            $display("FAIL ooo_wait: issue=%h, expected 0", issue);
        end
        tick();
        drive(nop, '0, '0, 1'b1);
        checks++;
        if (issue.rd.idx !== 6'd50 || issue !== exp_issue) begin
            failures++;
            $display("FAIL ooo_after_wakeup: issue=%h, expected %h (rd 50)", issue, exp_issue);
        end
        tick();
    endtask

    task automatic test_wakeup_enqueue();
        drive(mk(51, 0, 0, 0, 1, 45, 0), 7'h40 | 7'd45, '0, 1'b1);
        tick();
        drive(nop, '0, '0, 1'b1);
        checks++;
        if (issue.valid !== 1'b1 || issue.rd.idx !== 6'd51 || issue !== exp_issue) begin
            failures++;
            $display("FAIL wakeup_enqueue: issue=%h, expected %h (rd 51)", issue, exp_issue);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(mk(60 + i, 0, 0, 0, 0, 0, 0), '0, '0, 1'b0);
            tick();
        end
        drive(mk(63, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);
        checks++;
        if (issue.rd.idx !== 6'd60 || count !== 4'd3 || issue !== exp_issue) begin
            failures++;
            $display("FAIL b2b_first: issue=%h count=%0d, expected %h 3", issue, count, exp_issue);
        end
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(nop, '0, '0, 1'b1);
            checks++;
            if (issue.rd.idx !== 6'(60 + i) || issue !== exp_issue || count !== exp_count) begin
                failures++;
                $display("FAIL b2b_%0d: rd=%0d count=%0d, expected rd %0d count %0d", i, issue.rd.idx, count, 60 + i, exp_count);
            end
            if (i == 1) begin
                checks++;
                if (count !== 4'd3) begin
                    failures++;
                    $display("FAIL b2b_count: count=%0d, expected 3", count);
                end
            end
            tick();
        end
    endtask

    task automatic fill_ready(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(mk(base + i, 0, 0, 0, 0, 0, 0), '0, '0, 1'b0);
            tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
            drive(nop, '0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_flush();
        fill_ready(5, 10);
        drive(mk(20, 0, 0, 0, 0, 0, 0), '0, 2'b10, 1'b1);
        checks++;
        if (issue !== exp_issue) begin
            failures++;
            $display("FAIL flush_issue: issue=%h, expected %h", issue, exp_issue);
        end
`ifdef IQ_FLUSH_EN
        checks++;
        if (issue.valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_issue_valid: valid=%b, expected 0", issue.valid);
        end
`endif
        tick();
        drive(nop, '0, '0, 1'b0);
        checks++;
        if (count !== exp_count || full !== exp_full) begin
            failures++;
            $display("FAIL flush_count: count=%0d, expected %0d", count, exp_count);
        end
`ifdef IQ_FLUSH_EN
        checks++;
        if (count !== 4'd0) begin
            failures++;
            $display("FAIL flush_cleared: count=%0d, expected 0", count);
        end
`endif
        tick();
        drain();
        fill_ready(5, 10);
        drive(mk(21, 0, 0, 0, 0, 0, 0), '0, 2'b11, 1'b1);
        checks++;
        if (issue.valid !== 1'b1 || issue.rd.idx !== 6'd10 || issue !== exp_issue) begin
            failures++;
            $display("FAIL hit_issue: issue=%h, expected %h (rd 10)", issue, exp_issue);
        end
        tick();
        drive(nop, '0, '0, 1'b0);
        checks++;
        if (count !== 4'd5 || count !== exp_count) begin
            failures++;
            $display("FAIL hit_count: count=%0d, expected 5", count);
        end
        tick();
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(24 + i, 1, 9, 0, 0, 0, 0), '0, '0, 1'b0);
            tick();
        end
        @(negedge clk);
        rin = '0; wb = '0; br = '0; rdy = 1'b0;
        checks++;
        if (count !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d, expected 4", count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({issue, full, count} !== '0) begin
            failures++;
            $display("FAIL async_reset: issue=%h full=%b count=%0d, expected all zero", issue, full, count);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(30, 1, 9, 1, 0, 0, 0), '0, '0, 1'b0);
        checks++;
        if (count !== 4'd0 || {issue, full, count} !== {exp_issue, exp_full, exp_count}) begin
            failures++;
            $display("FAIL after_reset: issue=%h full=%b count=%0d, expected 0 0 0", issue, full, count);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        instr_t     r;
        logic [6:0] w;
        logic [1:0] b;
        for (int c = 0; c < 1000; c++) begin
            r = '0;
            r.valid     = ($urandom_range(0, 9) < 6);
            r.rd.valid  = $urandom_range(0, 1);
            r.rd.idx    = 6'($urandom_range(0, 63));
            r.rd.ready  = $urandom_range(0, 1);
            r.rs1.valid = ($urandom_range(0, 3) != 0);
            r.rs1.idx   = ($urandom_range(0, 8) == 0) ? 6'd0 : 6'(40 + $urandom_range(0, 7));
            r.rs1.ready = $urandom_range(0, 1);
            r.rs2.valid = ($urandom_range(0, 3) != 0);
            r.rs2.idx   = ($urandom_range(0, 8) == 0) ? 6'd0 : 6'(40 + $urandom_range(0, 7));
            r.rs2.ready = $urandom_range(0, 1);
            w[6]        = $urandom_range(0, 1);
            w[5:0]      = ($urandom_range(0, 8) == 0) ? 6'd0 : 6'(40 + $urandom_range(0, 7));
            b[1]        = ($urandom_range(0, 29) == 0);
            b[0]        = $urandom_range(0, 1);
            drive(r, w, b, ($urandom_range(0, 9) < 5));
            checks++;
            if ({issue, full, count} !== {exp_issue, exp_full, exp_count}) begin
                failures++;
                $display("FAIL random_%0d: issue=%h full=%b count=%0d, expected %h %b %0d", c, issue, full, count, exp_issue, exp_full, exp_count);
            end
            tick();
        end
    endtask

    initial begin
        nop = '0;
        test_reset();
        test_fill_issue();
        test_out_of_order();
        test_wakeup_enqueue();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Collapsing, age-ordered issue queue directly downstream of `rename`. It accepts renamed instructions (`rinstr_t`) in program order and holds them until all valid sources are ready. It wakes up waiting sources from the physical-register broadcast (`p_reg_t`) and issues the oldest ready entry to execute through a valid/ready handshake. Its full flag stalls decode alongside `rn_full_o`.

## Interface
- `DEPTH`, default 8: number of entries; must be ≥2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy count.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `rinstr_i`  in  `rinstr_t`  renamed instruction from `rename`. Fields: `valid`; `rd`/`rs1`/`rs2` each {`valid`, `idx[5:0]`, `ready`}.
- `p_wb_i`  in  `p_reg_t`  wakeup broadcast {`valid`, `idx[5:0]`}; same source as `rename.p_commit_i`.
- `br_result_i`  in  `br_result_t`  branch outcome {`valid`, `hit`}.
- `issue_ready_i`  in  1  execute stage can accept an instruction this cycle.
- `issue_o`  out  `rinstr_t`  selected instruction; `'0` when nothing is issuable.
- `iq_full_o`  out  1  queue cannot accept `rinstr_i` this cycle.
- `iq_count_o`  out  `CNT_W`  number of occupied entries.

## Operation
- **Storage.** `DEPTH` slots of `rinstr_t` plus a count.
  - Slots `[0 .. count-1]` are valid, and slot 0 is the oldest.
  - Slots at or above `count` hold `'0`.
- **Entry readiness.** An entry is ready = `(!rs1.valid || rs1.ready) && (!rs2.valid || rs2.ready)`.
- **Select.** Pick the lowest-index ready entry among `[0 .. count-1]`.
  - `issue_o` drives that entry combinationally from registered state.
  - If no entry is ready, `issue_o = '0`.
- **Issue.** An issue occurs when `issue_o.valid && issue_ready_i`. On the clock edge:
  - the issued slot is removed;
  - every slot above it shifts down by one;
  - count decrements.
- **Enqueue.** Accepted when `rinstr_i.valid && !iq_full_o`.
  - The entry is written at index `count` (or `count-1` if an issue also occurs in the same cycle).
  - Count increments.
  - A simultaneous enqueue and issue leaves count unchanged.
- **Full.** `iq_full_o = (count == DEPTH)`.
  - It depends only on registered count, with no same-cycle issue credit.
  - `rinstr_i.valid` while full is dropped; upstream must have stalled.
- **Wakeup.** When `p_wb_i.valid`, every source field with `valid && idx == p_wb_i.idx` gets `ready <= 1`.
  - This applies to stored entries, including their shifted positions, and to the entry being enqueued.
  - `idx == 0` is treated like any other index.
  - `rd` fields are never modified.
- **Flush.** Controlled by `IQ_FLUSH_EN`, see Configuration.
  - A flush clears all slots and sets count to 0.
  - It overrides enqueue, issue and wakeup in the same cycle.
  - `issue_o` is forced to `'0` during a flush cycle, so no handshake completes.
- **Invariant.** Entries never reorder except through removal-compaction, so age order is preserved.

## Timing
- **Reset.** While `rst_ni` is low:
  - all slots `'0`, count 0;
  - `issue_o = '0`, `iq_full_o = 0`, `iq_count_o = 0`.
  - Reset asserted mid-operation discards all entries immediately.
- **Enqueue to issue latency.** An entry enqueued with all sources ready is visible on `issue_o` in the next cycle. Minimum latency is 1 cycle.
- **Wakeup to issue latency.** A wakeup in cycle N makes the matching entry eligible in cycle N+1.
- **Issue rate.** At most one issue per cycle. `issue_o` may change in any cycle; it holds only while the selected entry stays oldest-ready.
- **Full transitions.** A count of `DEPTH` asserts `iq_full_o` the cycle after the filling enqueue. The flag deasserts the cycle after the first issue.

## Configuration
- **`IQ_FLUSH_EN` defined:**
  - `br_result_i.valid && !br_result_i.hit` triggers a flush in that cycle;
  - `br_result_i.valid && br_result_i.hit` has no effect.
- **`IQ_FLUSH_EN` undefined:**
  - `br_result_i` is ignored; the port remains present but unused;
  - no flush logic is generated.

## Test plan
- **Reset / fill / issue:** with `issue_ready_i=0`, enqueue 8 ready instructions (rd idx 32..39) → `iq_full_o=1`, count 8. Then set `issue_ready_i=1` → issue order is rd 32,33,…,39, one per cycle, and `iq_full_o=0` after the first issue.
- **Out-of-order issue:** slot 0 has rs1 idx 40 not ready; slot 1 is all ready (rd 41) → `issue_o.rd.idx=41` issues first. Then `p_wb_i={1,40}` → slot 0 issues on the next cycle.
- **Wakeup on enqueue:** enqueue rs2 idx 45 not ready while `p_wb_i={1,45}` in the same cycle → the entry issues in the next cycle.
- **Simultaneous enqueue + issue when count=3** → count stays 3, and the new entry sits at slot 2 behind the two survivors.
- **Flush (`IQ_FLUSH_EN`):** with count 5, drive `br_result_i={1,0}` together with `rinstr_i.valid=1` and `issue_ready_i=1` → `issue_o.valid=0` that cycle and count 0 next cycle. Repeat with `hit=1` → no change.
- **Async reset mid-operation:** drop `rst_ni` with count 4 → outputs are `'0` immediately, and count is 0 after release.
